// File: rtl/conv_result_collector.sv
// conv_result_collector
// ---------------------
// Downstream stage of the convolution unit. Results from the convolution
// operator are accepted through a valid/ready handshake and held in a small
// FIFO. Results are counted into fixed-length frames. The final result of
// each frame is tagged with out_last. frame_done pulses once that tagged
// result has been consumed.
//
// Parameters
//   DEPTH      FIFO entries (power of two, >= 2)
//   FRAME_LEN  results per frame (>= 1)
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset, released synchronously
//   in_result  result from the convolution operator
//   in_valid   in_result valid
//   in_ready   collector can accept a result (registered state only)
//   out_data   head-of-FIFO result
//   out_last   out_data is the last result of its frame
//   out_valid  out_data / out_last valid
//   out_ready  consumer accepts
//   frame_done one-cycle pulse, the cycle after a frame's last result popped
//   count      current occupancy, 0..DEPTH

package Conv;
  typedef logic [31:0] result_t;
endpackage

module conv_result_collector #(
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [$bits(Conv::result_t)-1:0]   in_result,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [$bits(Conv::result_t)-1:0]   out_data,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               frame_done,
  output logic [$clog2(DEPTH):0]             count
);

  localparam int DATA_W = $bits(Conv::result_t);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // A one-result frame still needs a 1-bit counter so the vector is legal.
  localparam int FC_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_LEN - 1);

  // Result payload storage; contents are not reset, only the bookkeeping is.
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  last_vec;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [FC_W-1:0]  frame_cnt_reg, frame_cnt_next;
  logic             frame_done_reg, frame_done_next;

  logic push;
  logic pop;
  logic push_last;

  // Handshake flags derive purely from the occupancy register, so a pop in
  // a full cycle never opens in_ready combinationally.
  assign in_ready  = (count_reg != CNT_FULL);
  assign out_valid = (count_reg != '0);

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push_last = (frame_cnt_reg == FC_LAST);

  assign out_data   = data_mem[rd_ptr_reg];
  // Gate the tag so a stale flag in an empty slot never shows up.
  assign out_last   = out_valid && last_vec[rd_ptr_reg];
  assign count      = count_reg;
  assign frame_done = frame_done_reg;

  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    count_next      = count_reg;
    frame_cnt_next  = frame_cnt_reg;
    frame_done_next = pop && out_last;

    if (push) begin
      wr_ptr_next    = wr_ptr_reg + PTR_W'(1);
      frame_cnt_next = push_last ? '0 : frame_cnt_reg + FC_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      frame_cnt_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      frame_cnt_reg  <= frame_cnt_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Payload RAM: single write port at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= in_result;
    end
  end

  // Per-entry frame-end flags, cleared by reset so no stale tag survives.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic wr_en;
      logic last_bit_reg;

      assign wr_en = push && (wr_ptr_reg == PTR_W'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          last_bit_reg <= 1'b0;
        end else if (wr_en) begin
          last_bit_reg <= push_last;
        end
      end

      assign last_vec[gi] = last_bit_reg;
    end
  endgenerate

endmodule

// File: tb/tb_conv_result_collector.sv
// Self-checking bench for conv_result_collector: a table of per-cycle
// vectors for fill/full behaviour, hand-written sequences for streaming,
// reset, random backpressure and single-result frames, all backed by a
// queue scoreboard that models occupancy and frame tagging.
module tb_conv_result_collector;

  localparam int DEPTH     = 8;
  localparam int FRAME_LEN = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] in_result;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;
  logic [3:0]  count;

  logic [31:0] u1_in_result;
  logic        u1_in_valid;
  logic        u1_in_ready;
  logic [31:0] u1_out_data;
  logic        u1_out_last;
  logic        u1_out_valid;
  logic        u1_out_ready;
  logic        u1_frame_done;
  logic [2:0]  u1_count;

  conv_result_collector #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_result  (in_result),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .count      (count)
  );

  conv_result_collector #(.DEPTH(4), .FRAME_LEN(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_result  (u1_in_result),
    .in_valid   (u1_in_valid),
    .in_ready   (u1_in_ready),
    .out_data   (u1_out_data),
    .out_last   (u1_out_last),
    .out_valid  (u1_out_valid),
    .out_ready  (u1_out_ready),
    .frame_done (u1_frame_done),
    .count      (u1_count)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } sb_t;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    int          e_cnt;
    logic [31:0] e_dat;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[22];

  int   n_vec  = 0;
  int   n_fail = 0;
  int   fcnt   = 0;
  logic exp_fd = 1'b0;
  int   n_last = 0;
  int   n_fd   = 0;
  logic last_push = 1'b0;

  logic u1_active = 1'b0;
  int   u1_pops   = 0;
  int   u1_fd     = 0;
  logic u1_exp_fd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at the falling edge: compares the pre-edge outputs with the
  // model, then advances the model by the handshake about to happen.
  task automatic sb_check();
    sb_t  e;
    logic do_push;
    logic do_pop;
    chk("count", 32'(count), 32'(sb.size()));
    chk("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    if (frame_done) n_fd++;
    if (sb.size() != 0) begin
      chk("out_data", out_data, sb[0].data);
      chk("out_last", 32'(out_last), 32'(sb[0].last));
    end
    do_pop  = out_ready && (sb.size() != 0);
    do_push = in_valid && (sb.size() != DEPTH);
    exp_fd  = 1'b0;
    if (do_pop) begin
      e = sb.pop_front();
      exp_fd = e.last;
      if (e.last) n_last++;
    end
    if (do_push) begin
      e.data = in_result;
      e.last = (fcnt == FRAME_LEN - 1);
      sb.push_back(e);
      fcnt = e.last ? 0 : fcnt + 1;
    end
    last_push = do_push;

    if (u1_active) begin
      chk("u1_frame_done", 32'(u1_frame_done), 32'(u1_exp_fd));
      if (u1_frame_done) u1_fd++;
      u1_exp_fd = 1'b0;
      if (u1_out_valid && u1_out_ready) begin
        chk("u1_out_last", 32'(u1_out_last), 32'd1);
        chk("u1_out_data", u1_out_data, 32'hA0 + 32'(u1_pops));
        u1_pops++;
        u1_exp_fd = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pushed;
    int cyc;

    // {in_valid, in_data, out_ready, exp in_ready, exp out_valid, exp count, exp out_data}
    vecs[0]  = '{1'b1, 32'd1,  1'b0, 1'b1, 1'b0, 0, 32'd0};
    vecs[1]  = '{1'b1, 32'd2,  1'b0, 1'b1, 1'b1, 1, 32'd1};
    vecs[2]  = '{1'b1, 32'd3,  1'b0, 1'b1, 1'b1, 2, 32'd1};
    vecs[3]  = '{1'b1, 32'd4,  1'b0, 1'b1, 1'b1, 3, 32'd1};
    vecs[4]  = '{1'b1, 32'd5,  1'b0, 1'b1, 1'b1, 4, 32'd1};
    vecs[5]  = '{1'b1, 32'd6,  1'b0, 1'b1, 1'b1, 5, 32'd1};
    vecs[6]  = '{1'b1, 32'd7,  1'b0, 1'b1, 1'b1, 6, 32'd1};
    vecs[7]  = '{1'b1, 32'd8,  1'b0, 1'b1, 1'b1, 7, 32'd1};
    vecs[8]  = '{1'b1, 32'd9,  1'b0, 1'b0, 1'b1, 8, 32'd1};
    vecs[9]  = '{1'b1, 32'd9,  1'b1, 1'b0, 1'b1, 8, 32'd1};
    vecs[10] = '{1'b1, 32'd9,  1'b0, 1'b1, 1'b1, 7, 32'd2};
    vecs[11] = '{1'b1, 32'd10, 1'b0, 1'b0, 1'b1, 8, 32'd2};
    vecs[12] = '{1'b1, 32'd10, 1'b1, 1'b0, 1'b1, 8, 32'd2};
    vecs[13] = '{1'b1, 32'd10, 1'b1, 1'b1, 1'b1, 7, 32'd3};
    vecs[14] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 7, 32'd4};
    vecs[15] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 6, 32'd5};
    vecs[16] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 5, 32'd6};
    vecs[17] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 4, 32'd7};
    vecs[18] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 3, 32'd8};
    vecs[19] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 2, 32'd9};
    vecs[20] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 1, 32'd10};
    vecs[21] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 0, 32'd0};

    rst = 1'b0;
    in_result = '0; in_valid = 1'b0; out_ready = 1'b0;
    u1_in_result = '0; u1_in_valid = 1'b0; u1_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    rst = 1'b1;

    // Streaming with frame marking: 32 results, lasts on 15 and 31.
    n_last = 0; n_fd = 0;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_result = 32'(i); out_ready = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("stream_last_count", 32'(n_last), 32'd2);
    chk("stream_frame_done_count", 32'(n_fd), 32'd2);
    $display("stream: 32 results, %0d lasts, %0d frame_done pulses", n_last, n_fd);

    // Fill / full / drain from the vector table.
    foreach (vecs[k]) begin
      in_valid = vecs[k].iv; in_result = vecs[k].id; out_ready = vecs[k].ordy;
      @(negedge clk);
      chk("tbl_in_ready", 32'(in_ready), 32'(vecs[k].e_ir));
      chk("tbl_out_valid", 32'(out_valid), 32'(vecs[k].e_ov));
      chk("tbl_count", 32'(count), 32'(vecs[k].e_cnt));
      if (vecs[k].e_ov) chk("tbl_out_data", out_data, vecs[k].e_dat);
      $display("vec %0d: iv=%0b id=%0d ordy=%0b -> in_ready=%0b out_valid=%0b count=%0d out_data=%0d",
               k, in_valid, in_result, out_ready, in_ready, out_valid, count, out_data);
      sb_check();
      @(posedge clk);
      #1;
    end

    // Reset mid-run with five results buffered.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_result = 32'h50 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("pre_reset_count", 32'(count), 32'd5);
    #1 rst = 1'b0;
    #1;
    chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
    chk("mid_reset_in_ready", 32'(in_ready), 32'd1);
    chk("mid_reset_count", 32'(count), 32'd0);
    chk("mid_reset_out_last", 32'(out_last), 32'd0);
    sb.delete(); fcnt = 0; exp_fd = 1'b0;
    #1 rst = 1'b1;
    in_valid = 1'b1; in_result = 32'h11;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_out_valid", 32'(out_valid), 32'd1);
    chk("post_reset_out_data", out_data, 32'h11);
    sb_check();
    @(posedge clk);
    #1;
    $display("reset: flushed 5 buffered results, first push 0x11 seen");

    // Random backpressure, 1000 results.
    pushed = 0; cyc = 0; in_valid = 1'b0;
    while (pushed < 1000 && cyc < 20000) begin
      if (!in_valid || last_push) begin
        in_valid  = ($urandom_range(0, 99) < 60);
        in_result = $urandom;
      end
      out_ready = ($urandom_range(0, 99) < 30);
      tick();
      if (last_push) pushed++;
      cyc++;
    end
    chk("bp_pushed", 32'(pushed), 32'd1000);
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("bp_drained", 32'(sb.size()), 32'd0);
    tick();
    $display("backpressure: %0d results pushed and drained", pushed);

    // FRAME_LEN = 1: every beat is a frame end.
    u1_active = 1'b1; u1_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u1_in_valid = 1'b1; u1_in_result = 32'hA0 + 32'(i);
      tick();
    end
    u1_in_valid = 1'b0;
    repeat (4) tick();
    chk("u1_pop_count", 32'(u1_pops), 32'd4);
    chk("u1_frame_done_count", 32'(u1_fd), 32'd4);
    $display("frame_len1: %0d pops, %0d frame_done pulses", u1_pops, u1_fd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
